window_3x3: RTL
===============

// Module: window_3x3
// PURPOSE
// Sliding-window generator sitting directly downstream of the padding stage.
// Consumes the padded raster stream (SIZE x SIZE pixels, one CHANNEL*N-bit pixel per valid beat).
// Emits every 3x3, stride-1 window in raster order for the convolution engine.
// Holds two line buffers and a 3x3 register window; input gaps of any length are tolerated.
// PARAMETERS
// N        8   bits per channel sample
// CHANNEL  3   channels packed per pixel; pixel width PW = CHANNEL*N
// SIZE     30  padded frame width = height (pixels); legal range 3..1023
// PORTS
// clk        in   1       clock, rising edge
// rst_n      in   1       asynchronous active-low reset
// clear      in   1       synchronous frame abort; clears counters and FSM
// din_vld    in   1       input pixel valid (connects to padding_dout_vld)
// din        in   PW      input pixel (connects to padding_dout)
// win_dout   out  9*PW    3x3 window; element k=3*i+j at [k*PW +: PW]; i = row (0 = top), j = col (0 = left)
// win_vld    out  1       one-cycle pulse, win_dout valid
// win_end    out  1       one-cycle pulse coincident with the last win_vld of a frame
// BEHAVIOUR
// - Reset (async, rst_n=0): win_vld=0, win_end=0, win_dout=0, row=col=0, state=S_FILL.
//   Line-buffer contents are not reset.
// - Counters: col, row (0..SIZE-1), $clog2(SIZE) bits each. They advance only when din_vld=1.
//   col wraps at SIZE-1 and increments row. At (row,col)=(SIZE-1,SIZE-1), both wrap to 0 on the next accepted pixel.
// - Line buffers lb0 and lb1, SIZE x PW each, indexed by col. On an accept at col c:
//   - new column = {top: lb1[c], mid: lb0[c], bot: din};
//   - lb1[c] <= lb0[c]; lb0[c] <= din (read-before-write, same edge).
// - Window regs w[i][j]: on accept, w[i][0] <= w[i][1], w[i][1] <= w[i][2], w[i][2] <= new column[i].
//   win_dout is driven directly from w. Hold when din_vld=0.
// - FSM:
//   - S_FILL (row<2) -> S_RUN on an accept at (1,SIZE-1).
//   - S_RUN -> S_FILL on an accept at (SIZE-1,SIZE-1).
//   - clear=1 -> S_FILL from any state.
// - win_vld <= din_vld & (state==S_RUN) & (col>=2). Latency is 1 cycle from the accepting edge.
//   The window covers rows row-2..row and cols col-2..col of the accepted pixel.
// - win_end <= din_vld & (row==SIZE-1) & (col==SIZE-1).
// - Windows per frame = (SIZE-2)^2. No window straddles a row boundary, because col<2 is gated.
//   Stale line-buffer data from a previous frame is never emitted, because rows 0..1 are gated by S_FILL.
// - Back-to-back frames: the first pixel of the next frame may arrive the cycle after the last pixel.
//   No bubble is required.
// - clear and din_vld in the same cycle: clear wins. The pixel is dropped, win_vld/win_end are 0 next cycle,
//   and counters become 0.
// - Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as (0,0).
// - No backpressure: the consumer must accept a window every cycle win_vld=1.
// - The padding stage emits zeros with vld=1 for border pixels. These are ordinary pixels here.
// TESTING (default bench: N=8, CHANNEL=1, SIZE=5, pixel value = 5*row+col)
// 1. Reset, then stream 25 pixels back-to-back -> 9 win_vld pulses.
//    First window (1 cycle after pixel 12) = {0,1,2,5,6,7,10,11,12} for k=0..8.
//    Last window = {12,13,14,17,18,19,22,23,24}, with win_end=1 on the same cycle.
// 2. Same frame with random 0-5 cycle gaps between pixels -> identical 9 windows and order.
//    win_vld is never asserted during gaps.
// 3. Two frames back-to-back (second frame = value+100) -> 18 windows.
//    The second frame's first window = {100,101,102,105,106,107,110,111,112}, with no frame-1 data mixed in.
// 4. Assert rst_n=0 asynchronously after pixel 17, then send a fresh full frame ->
//    outputs are 0 immediately during reset, and exactly 9 correct windows follow.
// 5. Pulse clear together with din_vld at pixel 8, then send a full frame -> no window for the dropped pixel,
//    and the next 25 pixels give 9 correct windows.
// 6. Rerun test 1 with CHANNEL=3, SIZE=30, and random data checked against a reference model ->
//    784 windows, with win_end only on the 784th.

Source files
------------

// File: rtl/window_3x3.sv
// 3x3 stride-1 sliding-window generator for a padded SIZE x SIZE raster stream.
// Two line buffers supply the upper rows; a 3x3 register array shifts left on each accepted pixel.
module window_3x3 #(
  parameter int N       = 8,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 30
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      din_vld,
  input  logic [CHANNEL*N-1:0]      din,
  output logic [9*CHANNEL*N-1:0]    win_dout,
  output logic                      win_vld,
  output logic                      win_end
);

  localparam int PW = CHANNEL * N;
  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic {
    S_FILL,
    S_RUN
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   row;
  logic [CW-1:0]   col;
  logic            accept;
  logic            at_row_end;
  logic            at_frame_end;
  logic            col_ready;
  logic [PW-1:0]   lb0 [SIZE];
  logic [PW-1:0]   lb1 [SIZE];
  logic [PW-1:0]   col_top;
  logic [PW-1:0]   col_mid;
  logic [PW-1:0]   w [3][3];

  // A pixel presented together with clear is dropped entirely.
  assign accept       = din_vld & ~clear;
  assign at_row_end   = (col == LAST);
  assign at_frame_end = at_row_end & (row == LAST);
  assign col_ready    = (col >= CW'(2));
  assign col_top      = lb1[col];
  assign col_mid      = lb0[col];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (at_row_end) begin
        col <= '0;
        row <= at_frame_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers read the old entry and overwrite it on the same edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          w[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        w[i][0] <= w[i][1];
        w[i][1] <= w[i][2];
      end
      w[0][2] <= col_top;
      w[1][2] <= col_mid;
      w[2][2] <= din;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      assign win_dout[(3*gi+gj)*PW +: PW] = w[gi][gj];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FILL;
    end else begin
      state <= state_next;
    end
  end

  // Rows 0..1 stay in S_FILL so stale line-buffer data never reaches the output.
  always_comb begin
    state_next = state;
    case (state)
      S_FILL: if (accept && (row == CW'(1)) && at_row_end) state_next = S_RUN;
      S_RUN:  if (accept && at_frame_end) state_next = S_FILL;
      default: state_next = S_FILL;
    endcase
    if (clear) state_next = S_FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_vld <= 1'b0;
      win_end <= 1'b0;
    end else begin
      win_vld <= accept & (state == S_RUN) & col_ready;
      win_end <= accept & at_frame_end;
    end
  end

endmodule
